// File: rtl/bitty_fetch_unit.sv
// bitty_fetch_unit: fetches 16-bit words from a synchronous memory and holds each on the core's run/instruction inputs until done.
// Optional EXEC watchdog enabled by defining BITTY_FETCH_TIMEOUT_EN.
`default_nettype none

module bitty_fetch_unit #(
  parameter int          ADDR_W         = 8,
  parameter logic [15:0] HALT_WORD      = 16'hFFFF,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       instruction,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       icount,
  output logic              busy,
  output logic              halted,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [15:0]        r_instr;
  logic [15:0]        r_icount;
  logic               r_stop_pending;
  logic               r_timeout;
  logic               w_start_load;
  logic               w_retire;
  logic               w_capture;
  logic               w_tmo_hit;
  logic               w_tmo_expire;
  logic               w_stop_req;
  logic               w_busy;

  assign w_busy     = (r_state == S_FETCH) || (r_state == S_LATCH) || (r_state == S_EXEC);
  // A stop arriving on the deciding edge is honoured as well as one already pending.
  assign w_stop_req = r_stop_pending || stop;

`ifdef BITTY_FETCH_TIMEOUT_EN
  logic [15:0] r_tcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcnt <= '0;
    end else if (r_state != S_EXEC) begin
      r_tcnt <= '0;
    end else if (!done) begin
      r_tcnt <= r_tcnt + 16'd1;
    end
  end

  assign w_tmo_expire = !done && (r_tcnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_param;
  assign w_unused_param = ^TIMEOUT_CYCLES;
  assign w_tmo_expire   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_start_load = 1'b0;
    w_retire     = 1'b0;
    w_capture    = 1'b0;
    w_tmo_hit    = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_start_load = 1'b1;
          w_next       = S_FETCH;
        end
      end
      S_FETCH: w_next = S_LATCH;
      S_LATCH: begin
        w_capture = 1'b1;
        if (mem_data == HALT_WORD || w_stop_req) begin
          w_next = S_HALT;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (done) begin
          w_retire = 1'b1;
          w_next   = w_stop_req ? S_HALT : S_FETCH;
        end else if (w_tmo_expire) begin
          w_tmo_hit = 1'b1;
          w_next    = S_HALT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc           <= '0;
      r_instr        <= '0;
      r_icount       <= '0;
      r_stop_pending <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      if (w_start_load) begin
        r_pc     <= start_addr;
        r_icount <= '0;
      end else if (w_retire) begin
        r_pc <= r_pc + 1'b1;
        if (r_icount != 16'hFFFF) begin
          r_icount <= r_icount + 16'd1;
        end
      end
      if (w_capture) begin
        r_instr <= mem_data;
      end
      if (w_next == S_HALT) begin
        r_stop_pending <= 1'b0;
      end else if (w_busy && stop) begin
        r_stop_pending <= 1'b1;
      end
      if (w_start_load) begin
        r_timeout <= 1'b0;
      end else if (w_tmo_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign mem_rd      = (r_state == S_FETCH);
  assign mem_addr    = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instr;
  assign run         = (r_state == S_EXEC);
  assign icount      = r_icount;
  assign busy        = w_busy;
  assign halted      = (r_state == S_HALT);
  assign timeout     = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_bitty_fetch_unit.sv
// Scoreboard bench for bitty_fetch_unit: a reference walk over the program memory predicts issues and halt state.
`default_nettype none

module tb_bitty_fetch_unit;

  localparam int TMO = 16;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
  } iss_t;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] cnt;
    logic        to;
  } fin_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  start_addr;
  logic        stop;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] instruction;
  logic        run;
  logic        done;
  logic [7:0]  pc;
  logic [15:0] icount;
  logic        busy;
  logic        halted;
  logic        timeout;

  logic        core_done = 1'b0;
  logic        idle_done = 1'b0;
  logic        core_en   = 1'b1;
  int          fixed_delay = 0;

  logic [15:0] mem [256];
  iss_t        exp_q[$];
  fin_t        fin_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          issue_cnt = 0;
  logic        prev_run = 1'b0;
  logic        prev_halted = 1'b0;
  logic [15:0] cur_instr = '0;

  assign done = core_done | idle_done;

  bitty_fetch_unit #(.ADDR_W(8), .HALT_WORD(16'hFFFF), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .stop(stop),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .instruction(instruction), .run(run), .done(done), .pc(pc), .icount(icount),
    .busy(busy), .halted(halted), .timeout(timeout)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Core model: answers each run with a done pulse after a few cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (run && core_en) begin
        int d;
        d = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(3, 6));
        repeat (d - 1) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues an instruction or halts.
  always @(negedge clk) begin
    if (run && !prev_run) begin
      issue_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL issue: got unexpected issue pc=%h instr=%h, required none", pc, instruction);
      end else begin
        iss_t e;
        e = exp_q.pop_front();
        chk("issue_pc", {24'd0, pc}, {24'd0, e.pc});
        chk("issue_instr", {16'd0, instruction}, {16'd0, e.instr});
        cur_instr = e.instr;
      end
    end else if (run) begin
      chk("instr_stable", {16'd0, instruction}, {16'd0, cur_instr});
    end
    if (halted && !prev_halted) begin
      if (fin_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL halt: got unexpected halt pc=%h, required none", pc);
      end else begin
        fin_t f;
        f = fin_q.pop_front();
        chk("halt_pc", {24'd0, pc}, {24'd0, f.pc});
        chk("halt_icount", {16'd0, icount}, {16'd0, f.cnt});
        chk("halt_timeout", {31'd0, timeout}, {31'd0, f.to});
      end
    end
    if (halted) chk("halt_quiet", {29'd0, run, mem_rd, busy}, 32'd0);
    prev_run    = run;
    prev_halted = halted;
  end

  // Reference: walk memory from s until the halt word or the k-th retirement.
  task automatic predict(input logic [7:0] s, input int stop_k);
    logic [7:0] a;
    int n;
    a = s;
    n = 0;
    while (mem[a] != 16'hFFFF) begin
      exp_q.push_back('{pc: a, instr: mem[a]});
      n++;
      a = a + 8'd1;
      if (stop_k != 0 && n == stop_k) break;
    end
    fin_q.push_back('{pc: a, cnt: 16'(n), to: 1'b0});
  endtask

  task automatic pulse_start(input logic [7:0] s);
    @(negedge clk);
    start_addr = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (halted) break;
      @(negedge clk);
    end
    chk("halt_reached", {31'd0, halted}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_issues(input int target);
    for (int i = 0; i < 1000; i++) begin
      if (issue_cnt >= target) break;
      @(negedge clk);
    end
    chk("issue_reached", {31'd0, issue_cnt >= target}, 32'd1);
  endtask

  task automatic prog_run(input logic [7:0] s, input int len, input int stop_k);
    int base;
    mem[8'(s + 8'(len))] = 16'hFFFF;
    predict(s, stop_k);
    base = issue_cnt;
    pulse_start(s);
    if (stop_k != 0) begin
      wait_issues(base + stop_k);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    wait_halt();
  endtask

  task automatic fill(input logic [7:0] s, input int len);
    for (int i = 0; i < len; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w == 16'hFFFF) w = 16'h0000;
      mem[8'(s + 8'(i))] = w;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    start_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outs", {mem_rd, run, busy, halted, timeout, pc, 7'd0, 16'd0},
        {32'd0});
    chk("reset_instr_icount", {instruction, icount}, 32'd0);

    idle_done = 1'b1;
    stop = 1'b1;
    repeat (3) @(negedge clk);
    idle_done = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    chk("idle_done_ignored", {27'd0, busy, halted, run, mem_rd, timeout}, 32'd0);

    fixed_delay = 3;
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    prog_run(8'h00, 2, 0);
    chk("prog_icount", {16'd0, icount}, 32'd2);

    mem[8'hFF] = 16'h0001;
    prog_run(8'hFF, 1, 0);
    chk("wrap_pc", {24'd0, pc}, 32'd0);

    fill(8'h40, 4);
    prog_run(8'h40, 4, 1);

    fixed_delay = 0;
    for (int t = 0; t < 10; t++) begin
      logic [7:0] s;
      int len, k;
      s = (t == 0) ? 8'hFA : 8'($urandom);
      len = int'($urandom_range(1, 10));
      k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len)) : 0;
      fill(s, len);
      prog_run(s, len, k);
    end

    begin
      int base;
      fill(8'h80, 6);
      mem[8'h86] = 16'hFFFF;
      base = issue_cnt;
      predict(8'h80, 0);
      pulse_start(8'h80);
      wait_issues(base + 2);
      #2 reset = 1'b1;
      #1;
      chk("async_run", {31'd0, run}, 32'd0);
      chk("async_pc", {24'd0, pc}, 32'd0);
      exp_q.delete();
      fin_q.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      chk("post_reset_idle", {30'd0, busy, halted}, 32'd0);
      prog_run(8'h80, 6, 0);
    end

    begin
      core_en = 1'b0;
      fill(8'hC0, 3);
      exp_q.push_back('{pc: 8'hC0, instr: mem[8'hC0]});
`ifdef BITTY_FETCH_TIMEOUT_EN
      fin_q.push_back('{pc: 8'hC0, cnt: 16'd0, to: 1'b1});
      pulse_start(8'hC0);
      wait_halt();
      chk("timeout_flag", {31'd0, timeout}, 32'd1);
      chk("timeout_icount", {16'd0, icount}, 32'd0);
`else
      pulse_start(8'hC0);
      repeat (100) @(negedge clk);
      chk("no_watchdog_run", {30'd0, run, timeout}, 32'd2);
`endif
      #2 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
    end

    chk("queues_drained", exp_q.size() + fin_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
